// File: rtl/phase_sched_if.sv
// Phase scheduler bus: stall request/acknowledge, single-step and the phase enables.
// The master drives requests and step; the slave (phase_sched) drives everything else.
interface phase_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] stall_req_i;
    logic            step_i;
    logic [NREQ-1:0] stall_ack_o;
    logic            halted_o;
    logic            phi1_o;
    logic            phi2_o;
    logic [15:0]     cyc_cnt_o;

    modport master (
        output stall_req_i, step_i,
        input  stall_ack_o, halted_o, phi1_o, phi2_o, cyc_cnt_o
    );

    modport slave (
        input  stall_req_i, step_i,
        output stall_ack_o, halted_o, phi1_o, phi2_o, cyc_cnt_o
    );
endinterface

// File: rtl/phase_sched.sv
// Two-phase clock-enable scheduler with stall drain/halt and a phase-cycle counter.
// Define PHASE_SCHED_STEP_EN to compile in single-stepping out of HALT.
module phase_sched #(
    parameter int NREQ = 4
) (
    input  logic         clk_i,
    input  logic         clear_i,
    phase_sched_if.slave bus
);

`ifdef PHASE_SCHED_STEP_EN
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2, STEP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [15:0] cyc_cnt_q;
    logic        any_req;
    logic        phi1;
    logic        phi2;

    assign any_req = |bus.stall_req_i;

    // Phase enables decode only registered state, so they are glitch-free and disjoint.
    assign phi1 = (cnt_q == 2'd1) && (state_q != HALT);
    assign phi2 = (cnt_q == 2'd3) && (state_q != HALT);

    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + 2'd1;
                if (any_req) begin
                    if (cnt_q == 2'd3) begin
                        state_d = HALT;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            // A begun phase cycle always runs to its phi2, even if the request drops.
            DRAIN: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = HALT;
                    cnt_d   = 2'd0;
                end
            end
            HALT: begin
                cnt_d = 2'd0;
                if (!any_req) begin
                    state_d = RUN;
                end
`ifdef PHASE_SCHED_STEP_EN
                else if (bus.step_i) begin
                    state_d = STEP;
                end
`endif
            end
`ifdef PHASE_SCHED_STEP_EN
            STEP: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = any_req ? HALT : RUN;
                    cnt_d   = 2'd0;
                end
            end
`endif
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            cyc_cnt_q <= 16'd0;
        end else if (phi2) begin
            cyc_cnt_q <= cyc_cnt_q + 16'd1;
        end
    end

`ifndef PHASE_SCHED_STEP_EN
    logic unused_step;
    assign unused_step = bus.step_i;
`endif

    assign bus.stall_ack_o = bus.stall_req_i & {NREQ{state_q == HALT}};
    assign bus.halted_o    = (state_q == HALT);
    assign bus.phi1_o      = phi1;
    assign bus.phi2_o      = phi2;
    assign bus.cyc_cnt_o   = cyc_cnt_q;

endmodule

// File: tb/tb_phase_sched.sv
// Bench for phase_sched: directed scenarios with literal expectations, then random
// requests/steps/resets compared every cycle against a phase-cycle reference model.
module tb_phase_sched;

    localparam int NREQ = 4;

    logic clk_i   = 1'b0;
    logic clear_i = 1'b0;

    phase_sched_if #(.NREQ(NREQ)) bus ();

    phase_sched #(.NREQ(NREQ)) dut (
        .clk_i   (clk_i),
        .clear_i (clear_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the phase cycle plus "stop pending" and
    // "single cycle granted" flags; a halt can only begin once a phase cycle is complete.
    bit          m_halted   = 1'b0;
    bit          m_stopping = 1'b0;
    bit          m_stepping = 1'b0;
    int          m_phase    = 0;
    logic [15:0] m_cyc      = 16'd0;
    bit          preload_pending = 1'b0;
    bit          preload_applied = 1'b0;

    always @(posedge clk_i or negedge clear_i or posedge preload_pending) begin
        if (!clear_i) begin
            m_halted   = 1'b0;
            m_stopping = 1'b0;
            m_stepping = 1'b0;
            m_phase    = 0;
            m_cyc      = 16'd0;
        end else if (preload_pending && !preload_applied) begin
            m_cyc           = 16'hFFFF;
            preload_applied = 1'b1;
        end else begin
            if (!preload_pending) preload_applied = 1'b0;
            if (m_halted) begin
                if (bus.stall_req_i == '0) begin
                    m_halted = 1'b0;
                end
`ifdef PHASE_SCHED_STEP_EN
                else if (bus.step_i) begin
                    m_halted   = 1'b0;
                    m_stepping = 1'b1;
                end
`endif
            end else if (m_phase == 3) begin
                m_cyc      = m_cyc + 16'd1;
                m_halted   = m_stopping || (bus.stall_req_i != '0);
                m_stopping = 1'b0;
                m_stepping = 1'b0;
                m_phase    = 0;
            end else begin
                if (!m_stepping && (bus.stall_req_i != '0)) m_stopping = 1'b1;
                m_phase = m_phase + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("model_phi1",   bus.phi1_o,      !m_halted && (m_phase == 1));
        checkOutput("model_phi2",   bus.phi2_o,      !m_halted && (m_phase == 3));
        checkOutput("model_halted", bus.halted_o,    m_halted);
        checkOutput("model_ack",    bus.stall_ack_o, bus.stall_req_i & {NREQ{m_halted}});
        checkOutput("model_cyc",    bus.cyc_cnt_o,   m_cyc);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic stp);
        #1;
        bus.stall_req_i = req;
        bus.step_i      = stp;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_phi1"},   bus.phi1_o,      0);
        checkOutput({tag, "_phi2"},   bus.phi2_o,      0);
        checkOutput({tag, "_halted"}, bus.halted_o,    0);
        checkOutput({tag, "_ack"},    bus.stall_ack_o, 0);
        checkOutput({tag, "_cyc"},    bus.cyc_cnt_o,   0);
    endtask

    initial begin
        logic [NREQ-1:0] rnd_req;
        bit              found;
        int              p1;
        int              p2;
        rnd_req = '0;
        bus.stall_req_i = '0;
        bus.step_i      = 1'b0;

        fork
            forever begin
                @(negedge clk_i);
                compareModel();
            end
        join_none

        // Reset: outputs zero even with clock running and requests high.
        #2;
        checkAllZero("reset");
        applyStimulus('1, 1'b1);
        repeat (2) @(negedge clk_i);
        checkAllZero("reset_req");
        applyStimulus('0, 1'b0);
        clear_i = 1'b1;

        // Free run: phi1 at cnt 1, phi2 at cnt 3, four phase cycles in 16 edges.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_i);
            checkOutput("free_phi1", bus.phi1_o, (k % 4) == 1);
            checkOutput("free_phi2", bus.phi2_o, (k % 4) == 3);
        end
        checkOutput("free_cyc16", bus.cyc_cnt_o, 4);

        // Request at cnt 1: drain through phi2, then halt with cyc frozen.
        @(negedge clk_i);
        checkOutput("drain_phi1", bus.phi1_o, 1);
        applyStimulus(4'b0001, 1'b0);
        @(negedge clk_i);
        checkOutput("drain_not_halted", bus.halted_o, 0);
        checkOutput("drain_ack", bus.stall_ack_o, 0);
        @(negedge clk_i);
        checkOutput("drain_phi2", bus.phi2_o, 1);
        @(negedge clk_i);
        checkOutput("drain_halted", bus.halted_o, 1);
        checkOutput("drain_ack_0001", bus.stall_ack_o, 4'b0001);
        checkOutput("drain_cyc", bus.cyc_cnt_o, 5);
        repeat (4) @(negedge clk_i);
        checkOutput("halt_cyc_frozen", bus.cyc_cnt_o, 5);
        checkOutput("halt_no_phi2", bus.phi2_o, 0);

        // Release, then request exactly at cnt 3: phi2 still fires, halt without drain.
        applyStimulus('0, 1'b0);
        @(negedge clk_i);
        checkOutput("resume_halted", bus.halted_o, 0);
        repeat (3) @(negedge clk_i);
        checkOutput("late_req_phi2", bus.phi2_o, 1);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk_i);
        checkOutput("late_req_halted", bus.halted_o, 1);
        checkOutput("late_req_ack", bus.stall_ack_o, 4'b0010);
        checkOutput("late_req_cyc", bus.cyc_cnt_o, 6);

        // Single step from HALT with req 0011.
        applyStimulus(4'b0011, 1'b1);
        @(negedge clk_i);
        applyStimulus(4'b0011, 1'b0);
        p1 = 0;
        p2 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (bus.phi1_o) p1++;
            if (bus.phi2_o) p2++;
        end
`ifdef PHASE_SCHED_STEP_EN
        checkOutput("step_phi1_count", p1, 1);
        checkOutput("step_phi2_count", p2, 1);
        checkOutput("step_cyc", bus.cyc_cnt_o, 7);
`else
        checkOutput("step_phi1_count", p1, 0);
        checkOutput("step_phi2_count", p2, 0);
        checkOutput("step_cyc", bus.cyc_cnt_o, 6);
`endif
        checkOutput("step_halted", bus.halted_o, 1);
        checkOutput("step_ack", bus.stall_ack_o, 4'b0011);

        // Preload the cycle counter to 0xFFFF while halted, then one phi2 wraps it.
        @(posedge clk_i);
        #1;
        force dut.cyc_cnt_q = 16'hFFFF;
        preload_pending = 1'b1;
        @(negedge clk_i);
        checkOutput("preload_cyc", bus.cyc_cnt_o, 16'hFFFF);
        @(posedge clk_i);
        #1;
        release dut.cyc_cnt_q;
        preload_pending = 1'b0;
        @(negedge clk_i);
        checkOutput("preload_kept", bus.cyc_cnt_o, 16'hFFFF);
        applyStimulus('0, 1'b0);
        repeat (4) @(negedge clk_i);
        checkOutput("wrap_phi2", bus.phi2_o, 1);
        checkOutput("wrap_before", bus.cyc_cnt_o, 16'hFFFF);
        @(negedge clk_i);
        checkOutput("wrap_after", bus.cyc_cnt_o, 16'h0000);

        // Reset in the middle of DRAIN, then a clean free-run restart.
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk_i);
            if (bus.phi1_o) found = 1'b1;
        end
        checkOutput("wait_phi1", found, 1);
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk_i);
        checkOutput("mid_drain_halted", bus.halted_o, 0);
        #1;
        clear_i = 1'b0;
        #1;
        checkAllZero("clear_now");
        @(negedge clk_i);
        checkAllZero("clear_held");
        applyStimulus('0, 1'b0);
        clear_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            checkOutput("restart_phi1", bus.phi1_o, k == 1);
            checkOutput("restart_phi2", bus.phi2_o, k == 3);
            checkOutput("restart_cyc", bus.cyc_cnt_o, (k == 4) ? 1 : 0);
        end

        // Random requests, steps and occasional resets against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 1) == 0) rnd_req = '0;
                else rnd_req = NREQ'($urandom);
            end
            applyStimulus(rnd_req, $urandom_range(0, 7) == 0);
            clear_i = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk_i);
        clear_i = 1'b1;
        repeat (4) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
